// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for pipe_stage_reg: exception cause codes and entry-record widths.
package pipe_stage_reg_pkg;

    localparam int CAUSE_W = 5;

    typedef logic [CAUSE_W-1:0] exc_cause_t;

    localparam exc_cause_t EXC_CAUSE_NONE = 5'd0;
    localparam exc_cause_t EXC_CAUSE_ADEL = 5'd4;
    localparam exc_cause_t EXC_CAUSE_ADES = 5'd5;

    // Entry record is {data, cause, delay-slot}; this is the width beyond the payload.
    localparam int ENTRY_TAG_W = CAUSE_W + 1;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle between pipeline stages; the stage register binds to the slave modport.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 64
);
    import pipe_stage_reg_pkg::*;

    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data;
    exc_cause_t       i_except_cause;
    logic             i_bad_addr;
    logic             i_dmem_we;
    logic             i_prev_is_branch;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    exc_cause_t       o_except_cause;
    logic             o_in_delay_slot;

    // Environment side: drives upstream payload and downstream ready.
    modport master (
        output i_valid, i_data, i_except_cause, i_bad_addr, i_dmem_we,
               i_prev_is_branch, i_flush, i_ready,
        input  o_ready, o_valid, o_data, o_except_cause, o_in_delay_slot
    );

    modport slave (
        input  i_valid, i_data, i_except_cause, i_bad_addr, i_dmem_we,
               i_prev_is_branch, i_flush, i_ready,
        output o_ready, o_valid, o_data, o_except_cause, o_in_delay_slot
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// Two-entry (main + skid) FIFO-ordered buffer for pipe_stage_reg.
// Only exists when PIPE_STAGE_SKID_EN is defined.
`ifdef PIPE_STAGE_SKID_EN
module pipe_skid_buf #(
    parameter int           W           = 70,
    parameter logic [W-1:0] RESET_ENTRY = '0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_push,
    input  logic [W-1:0] i_entry,
    input  logic         i_pop_rdy,
    input  logic         i_flush,
    input  logic [W-1:0] i_flush_entry,
    output logic         o_vld,
    output logic [W-1:0] o_entry,
    output logic         o_full
);

    logic         r_main_vld_p1;
    logic [W-1:0] r_main_p1;
    logic         r_skid_vld_p1;
    logic [W-1:0] r_skid_p1;
    logic         w_main_free;

    assign w_main_free = !r_main_vld_p1 || i_pop_rdy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_main_vld_p1 <= 1'b0;
            r_main_p1     <= RESET_ENTRY;
            r_skid_vld_p1 <= 1'b0;
            r_skid_p1     <= RESET_ENTRY;
        end else if (i_flush) begin
            r_main_vld_p1 <= 1'b0;
            r_main_p1     <= i_flush_entry;
            r_skid_vld_p1 <= 1'b0;
        end else if (w_main_free) begin
            // Skid entry is older than anything arriving now, so it moves up first.
            if (r_skid_vld_p1) begin
                r_main_p1     <= r_skid_p1;
                r_main_vld_p1 <= 1'b1;
                r_skid_vld_p1 <= 1'b0;
            end else if (i_push) begin
                r_main_p1     <= i_entry;
                r_main_vld_p1 <= 1'b1;
            end else begin
                r_main_vld_p1 <= 1'b0;
            end
        end else if (i_push) begin
            r_skid_p1     <= i_entry;
            r_skid_vld_p1 <= 1'b1;
        end
    end

    assign o_vld   = r_main_vld_p1;
    assign o_entry = r_main_p1;
    assign o_full  = r_skid_vld_p1;

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush-to-bubble, cause merging and delay-slot tag.
// Define PIPE_STAGE_SKID_EN to add a skid entry and register o_ready.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] CTRL_MASK = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             resetn,
    pipe_stage_reg_if.slave  bus
);

    localparam int EW = WIDTH + ENTRY_TAG_W;
    localparam logic [EW-1:0] RESET_ENTRY = {RESET_VAL, EXC_CAUSE_NONE, 1'b0};

    function automatic exc_cause_t merge_cause(input logic bad_addr, input logic dmem_we,
                                               input exc_cause_t cause);
        if (bad_addr) return dmem_we ? EXC_CAUSE_ADES : EXC_CAUSE_ADEL;
        return cause;
    endfunction

    logic             w_xfer_in;
    logic [EW-1:0]    w_entry_in;
    logic             w_main_vld;
    logic [EW-1:0]    w_main;
    logic [WIDTH-1:0] w_main_data;
    logic [EW-1:0]    w_flush_entry;

    assign w_xfer_in   = bus.i_valid && bus.o_ready;
    assign w_entry_in  = {bus.i_data,
                          merge_cause(bus.i_bad_addr, bus.i_dmem_we, bus.i_except_cause),
                          bus.i_prev_is_branch};
    assign w_main_data = w_main[EW-1 -: WIDTH];
    // Flush resets control bits only; data bits keep their last value.
    assign w_flush_entry = {(w_main_data & ~CTRL_MASK) | (RESET_VAL & CTRL_MASK),
                            EXC_CAUSE_NONE, 1'b0};

`ifdef PIPE_STAGE_SKID_EN
    logic w_skid_full;

    pipe_skid_buf #(
        .W           (EW),
        .RESET_ENTRY (RESET_ENTRY)
    ) u_skid (
        .clk           (clk),
        .resetn        (resetn),
        .i_push        (w_xfer_in),
        .i_entry       (w_entry_in),
        .i_pop_rdy     (bus.i_ready),
        .i_flush       (bus.i_flush),
        .i_flush_entry (w_flush_entry),
        .o_vld         (w_main_vld),
        .o_entry       (w_main),
        .o_full        (w_skid_full)
    );

    // Ready comes from the skid register; flush forces it so the killed input is consumed.
    assign bus.o_ready = !w_skid_full || bus.i_flush;
`else
    logic          r_vld_p1;
    logic [EW-1:0] r_entry_p1;

    assign bus.o_ready = bus.i_ready || !r_vld_p1 || bus.i_flush;

    // Stage p0 -> p1: capture, drain or flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vld_p1   <= 1'b0;
            r_entry_p1 <= RESET_ENTRY;
        end else if (bus.i_flush) begin
            r_vld_p1   <= 1'b0;
            r_entry_p1 <= w_flush_entry;
        end else if (w_xfer_in) begin
            r_vld_p1   <= 1'b1;
            r_entry_p1 <= w_entry_in;
        end else if (r_vld_p1 && bus.i_ready) begin
            r_vld_p1   <= 1'b0;
        end
    end

    assign w_main_vld = r_vld_p1;
    assign w_main     = r_entry_p1;
`endif

    assign bus.o_valid = w_main_vld;
    assign {bus.o_data, bus.o_except_cause, bus.o_in_delay_slot} = w_main;

endmodule
